// File: rtl/score_bcd_scanner_pkg.sv
// Shared constants, FSM state type and the double-dabble nibble adjust used by
// the score BCD scanner.
package score_bcd_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam int unsigned BCD_MAX    = 9999;
  localparam logic [3:0]  AN_IDLE    = 4'b1110;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } conv_state_e;

  // Add 3 to every nibble that is >= 5, ahead of the next left shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_bcd_scanner_if.sv
// Score load handshake plus the multiplexed BCD/anode display bus.
interface score_bcd_scanner_if #(
  parameter int unsigned BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             load;
  logic             busy;
  logic             overflow;
  logic [3:0]       bcd_out;
  logic [3:0]       an;

  modport master (output bin_in, load, input busy, overflow, bcd_out, an);
  modport slave  (input bin_in, load, output busy, overflow, bcd_out, an);
endinterface

// File: rtl/score_bcd_scanner_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle for BIN_W cycles, then a
// single UPDATE cycle in which done is high and bcd holds the result.
module score_bcd_scanner_bin2bcd_seq
  import score_bcd_scanner_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      bcd,
  output logic             done
);

  localparam int unsigned CW = $clog2(BIN_W + 1);

  conv_state_e      state_q;
  logic [BIN_W-1:0] bin_q;
  logic [15:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            bin_q   <= (32'(bin_in) > BCD_MAX) ? BIN_W'(BCD_MAX) : bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= (32'(bin_in) > BCD_MAX);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          {bcd_q, bin_q} <= {dd_adjust(bcd_q), bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_q <= StUpdate;
        end
        StUpdate: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
  // Combinational so the display copy lands on the UPDATE edge itself.
  assign done     = (state_q == StUpdate);

endmodule

// File: rtl/score_bcd_scanner.sv
// Score to 4-digit BCD converter feeding a time-multiplexed 7-segment digit
// scanner with optional leading-zero blanking.
module score_bcd_scanner
  import score_bcd_scanner_pkg::*;
#(
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  score_bcd_scanner_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  logic          conv_busy;
  logic          conv_ovf;
  logic          conv_done;
  logic [15:0]   conv_bcd;

  logic [15:0]   disp_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [3:0]    bcd_out_q;

  logic [3:0]    lz;
  logic [3:0]    digit;
  logic [3:0]    shown;

  score_bcd_scanner_bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bus.bin_in),
    .load    (bus.load),
    .busy    (conv_busy),
    .overflow(conv_ovf),
    .bcd     (conv_bcd),
    .done    (conv_done)
  );

  // lz[k]: digit k and all more-significant digits are zero; units never blank.
  always_comb begin
    lz    = '0;
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    digit = disp_q[{idx_q, 2'b00} +: 4];
    shown = (BLANK_LZ && lz[idx_q]) ? BCD_BLANK : digit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      an_q      <= AN_IDLE;
      bcd_out_q <= '0;
    end else begin
      if (conv_done) disp_q <= conv_bcd;
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      an_q      <= ~(4'b0001 << idx_q);
      bcd_out_q <= shown;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.overflow = conv_ovf;
  assign bus.an       = an_q;
  assign bus.bcd_out  = bcd_out_q;

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Directed bench: two scanners (blanking on/off) share clock, reset and stimulus.
module tb_score_bcd_scanner;

  localparam int unsigned BIN_W = 14;
  localparam int unsigned DIV   = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  score_bcd_scanner_if #(.BIN_W(BIN_W)) bus_a ();
  score_bcd_scanner_if #(.BIN_W(BIN_W)) bus_b ();

  score_bcd_scanner #(.BIN_W(BIN_W), .REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  score_bcd_scanner #(.BIN_W(BIN_W), .REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  task automatic drive(input logic [BIN_W-1:0] v, input logic l);
    bus_a.bin_in = v;
    bus_a.load   = l;
    bus_b.bin_in = v;
    bus_b.load   = l;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle load pulse; returns once busy drops (bounded).
  task automatic do_load(input logic [BIN_W-1:0] v, output bit ok);
    int n;
    drive(v, 1'b1);
    tick(1);
    drive('0, 1'b0);
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    ok = (n < 100);
    tick(2);
  endtask

  // Collect the digit shown under each anode; digs = {d3,d2,d1,d0}.
  task automatic capture(input bit sel, output logic [15:0] digs, output bit ok);
    logic [3:0] tgt;
    logic [3:0] cur;
    int n;
    ok   = 1'b1;
    digs = '0;
    for (int k = 0; k < 4; k++) begin
      tgt = ~(4'b0001 << k);
      n   = 0;
      cur = sel ? bus_b.an : bus_a.an;
      while (cur !== tgt && n < 64) begin
        tick(1);
        n++;
        cur = sel ? bus_b.an : bus_a.an;
      end
      if (n >= 64) ok = 1'b0;
      digs[k*4 +: 4] = sel ? bus_b.bcd_out : bus_a.bcd_out;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    bit ok;
    int n;
    rst = 1'b1;
    drive('0, 1'b0);
    tick(2);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus_a.overflow); end
    total++; if (bus_a.an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", bus_a.an); end
    total++; if (bus_a.bcd_out !== 4'h0) begin bad++; $display("FAIL reset_bcd got=%h want=0", bus_a.bcd_out); end
    rst = 1'b0;
    n = 0;
    while (bus_a.an !== 4'b1101 && n < 32) begin tick(1); n++; end
    total++; if (n >= 32) begin bad++; $display("FAIL scan_start got=%b want=1101", bus_a.an); end
    tick(3);
    total++; if (bus_a.an !== 4'b1101) begin bad++; $display("FAIL scan_hold got=%b want=1101", bus_a.an); end
    tick(1);
    total++; if (bus_a.an !== 4'b1011) begin bad++; $display("FAIL scan_an2 got=%b want=1011", bus_a.an); end
    tick(4);
    total++; if (bus_a.an !== 4'b0111) begin bad++; $display("FAIL scan_an3 got=%b want=0111", bus_a.an); end
    tick(4);
    total++; if (bus_a.an !== 4'b1110) begin bad++; $display("FAIL scan_wrap got=%b want=1110", bus_a.an); end
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'hFFF0) begin bad++; $display("FAIL reset_disp_a got=%h want=fff0", d); end
    capture(1'b1, d, ok);
    total++; if (!ok || d !== 16'h0000) begin bad++; $display("FAIL reset_disp_b got=%h want=0000", d); end
  endtask

  task automatic test_convert();
    logic [15:0] d;
    bit ok;
    drive(14'd1234, 1'b1);
    tick(1);
    drive('0, 1'b0);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", bus_a.busy); end
    tick(14);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL busy_e14 got=%b want=1", bus_a.busy); end
    tick(1);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL busy_e15 got=%b want=0", bus_a.busy); end
    tick(2);
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'h1234) begin bad++; $display("FAIL disp_1234 got=%h want=1234", d); end
    total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL ovf_1234 got=%b want=0", bus_a.overflow); end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    bit ok;
    do_load(14'd12000, ok);
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'h9999) begin bad++; $display("FAIL disp_sat got=%h want=9999", d); end
    total++; if (bus_a.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", bus_a.overflow); end
    do_load(14'd7, ok);
    total++; if (bus_a.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", bus_a.overflow); end
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'hFFF7) begin bad++; $display("FAIL disp_7a got=%h want=fff7", d); end
    capture(1'b1, d, ok);
    total++; if (!ok || d !== 16'h0007) begin bad++; $display("FAIL disp_7b got=%h want=0007", d); end
  endtask

  task automatic test_busy_drop();
    logic [15:0] d;
    bit ok;
    int n;
    drive(14'd5678, 1'b1);
    tick(1);
    drive('0, 1'b0);
    tick(4);
    drive(14'd1111, 1'b1);
    tick(1);
    drive('0, 1'b0);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b want=1", bus_a.busy); end
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 100) begin tick(1); n++; end
    total++; if (n >= 100) begin bad++; $display("FAIL drop_timeout got=%b want=0", bus_a.busy); end
    tick(3);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL drop_requeue got=%b want=0", bus_a.busy); end
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'h5678) begin bad++; $display("FAIL disp_5678 got=%h want=5678", d); end
  endtask

  task automatic test_inner_zero();
    logic [15:0] d;
    bit ok;
    do_load(14'd105, ok);
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'hF105) begin bad++; $display("FAIL disp_105a got=%h want=f105", d); end
    capture(1'b1, d, ok);
    total++; if (!ok || d !== 16'h0105) begin bad++; $display("FAIL disp_105b got=%h want=0105", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    bit ok;
    int n;
    drive(14'd300, 1'b1);
    tick(1);
    drive(14'd42, 1'b1);
    tick(15);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL b2b_update got=%b want=0", bus_a.busy); end
    tick(1);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", bus_a.busy); end
    drive('0, 1'b0);
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 100) begin tick(1); n++; end
    tick(2);
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'hFF42) begin bad++; $display("FAIL disp_42 got=%h want=ff42", d); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    bit ok;
    drive(14'd4321, 1'b1);
    tick(1);
    drive('0, 1'b0);
    tick(7);
    #2 rst = 1'b1;
    #1;
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_a.an !== 4'b1110) begin bad++; $display("FAIL mid_an got=%b want=1110", bus_a.an); end
    total++; if (bus_a.bcd_out !== 4'h0) begin bad++; $display("FAIL mid_bcd got=%h want=0", bus_a.bcd_out); end
    tick(1);
    rst = 1'b0;
    tick(40);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", bus_a.busy); end
    capture(1'b0, d, ok);
    total++; if (!ok || d !== 16'hFFF0) begin bad++; $display("FAIL mid_disp_a got=%h want=fff0", d); end
    capture(1'b1, d, ok);
    total++; if (!ok || d !== 16'h0000) begin bad++; $display("FAIL mid_disp_b got=%h want=0000", d); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_busy_drop();
    test_inner_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
